// File: rtl/seven_seg_pkg.sv
// Shared types and sizing helpers for the seven-segment scan controller.
// Contents:
//   scanState_t - scan FSM state (BLANK: all anodes off, SHOW: one digit lit)
//   cntWidth    - dwell/blank counter width from the two interval lengths
//   idxWidth    - digit index width from the digit count
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scanState_t;

  // Width able to hold 0..max(dwell, blankCycles)-1, never less than one bit.
  function automatic int unsigned cntWidth(input int unsigned dwell,
                                           input int unsigned blankCycles);
    int unsigned longest;
    longest = (dwell > blankCycles) ? dwell : blankCycles;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

  // Width able to hold digit indices 0..numDigits-1, never less than one bit.
  function automatic int unsigned idxWidth(input int unsigned numDigits);
    return (numDigits < 2) ? 1 : $clog2(numDigits);
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode hex digits
// sharing one external hex-to-seven-segment decoder. Digits are lit in
// order 0..NUM_DIGITS-1 for DWELL clocks each, separated by BLANK_CYCLES
// clocks with every anode off. A loaded value is double buffered and only
// takes effect at the start of a frame, so a frame never mixes two values.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   load       - one-cycle strobe capturing value
//   value      - packed nibbles, nibble i = value[4i+3:4i], digit 0 rightmost
//   lz_blank   - 1 = suppress leading zeros (taken at each digit's SHOW entry)
//   dec_in     - nibble presented to the shared decoder (held during BLANK)
//   an_n       - active-low anode enables, at most one bit low
//   seg_blank  - 1 = force segments off
//   frame_done - one-cycle pulse on the first BLANK cycle after the last digit
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL        = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_blank,
  output logic [3:0]              dec_in,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    seg_blank,
  output logic                    frame_done
);

  localparam int unsigned CntW = cntWidth(DWELL, BLANK_CYCLES);
  localparam int unsigned IdxW = idxWidth(NUM_DIGITS);
  localparam int unsigned ValW = 4 * NUM_DIGITS;

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  scanState_t      state;
  logic [CntW-1:0] cnt;
  logic [IdxW-1:0] idx;
  logic [ValW-1:0] active;
  logic [ValW-1:0] pending;
  logic            pendV;

  logic                  blankDone;
  logic                  showDone;
  logic                  frameStart;
  logic [ValW-1:0]       entryActive;
  logic [NUM_DIGITS-1:0] zeroFrom;
  logic                  runZero;
  logic                  suppress;

  // Interval ends and the value that will be active once the next SHOW starts.
  // A load on the frame-start edge bypasses the pending buffer.
  always_comb begin
    blankDone   = (state == BLANK) && (cnt == BlankLast);
    showDone    = (state == SHOW) && (cnt == DwellLast);
    frameStart  = blankDone && (idx == '0);
    entryActive = active;
    if (frameStart) begin
      if (load) begin
        entryActive = value;
      end else if (pendV) begin
        entryActive = pending;
      end
    end
  end

  // zeroFrom[i] is set when nibbles i..NUM_DIGITS-1 of active are all zero.
  // Digit 0 is never suppressed, so the active swap at frame start can use
  // the current active value here.
  always_comb begin
    zeroFrom = '0;
    runZero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      runZero     = runZero && (active[4*i +: 4] == 4'h0);
      zeroFrom[i] = runZero;
    end
    suppress = lz_blank && (idx != '0) && zeroFrom[idx];
  end

  // Scan FSM, double buffer and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      pending    <= '0;
      pendV      <= 1'b0;
      an_n       <= '1;
      seg_blank  <= 1'b1;
      dec_in     <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (frameStart) begin
        active <= entryActive;
        pendV  <= 1'b0;
      end else if (load) begin
        pending <= value;
        pendV   <= 1'b1;
      end

      case (state)
        BLANK: begin
          if (blankDone) begin
            state  <= SHOW;
            cnt    <= '0;
            dec_in <= entryActive[4*idx +: 4];
            if (suppress) begin
              an_n      <= '1;
              seg_blank <= 1'b1;
            end else begin
              an_n      <= ~(NUM_DIGITS'(1) << idx);
              seg_blank <= 1'b0;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        SHOW: begin
          if (showDone) begin
            state     <= BLANK;
            cnt       <= '0;
            an_n      <= '1;
            seg_blank <= 1'b1;
            if (idx == IdxLast) begin
              idx        <= '0;
              frame_done <= 1'b1;
            end else begin
              idx <= idx + IdxW'(1);
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (4 digits, dwell 4, blank 2).
// A reference model derives every cycle's expected outputs from the frame
// position (cycle count modulo the frame period) and queues them; a monitor
// pops and compares one entry per clock. Directed checks cover the fixed
// cycle numbers of the first frame and the mid-scan reset.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned ND   = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned BL   = 2;
  localparam int unsigned SLOT = BL + DW;
  localparam int unsigned PER  = ND * SLOT;

  logic            clk = 1'b0;
  logic            reset;
  logic            load;
  logic [4*ND-1:0] value;
  logic            lz_blank;
  logic [3:0]      dec_in;
  logic [ND-1:0]   an_n;
  logic            seg_blank;
  logic            frame_done;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL       (DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .value     (value),
    .lz_blank  (lz_blank),
    .dec_in    (dec_in),
    .an_n      (an_n),
    .seg_blank (seg_blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    dec;
    logic [ND-1:0] an;
    logic          sb;
    logic          fd;
  } exp_t;

  exp_t expQ[$];
  exp_t mexp;
  int   nChecks = 0;
  int   nFails  = 0;

  // Reference model state: pos is the frame position of the cycle that
  // follows the most recent modelled edge.
  int unsigned     pos = 0;
  bit [4*ND-1:0]   frameVal = '0;
  bit [4*ND-1:0]   pendVal = '0;
  bit              pendV = 1'b0;
  bit [3:0]        lastDec = 4'h0;
  bit              curSup = 1'b0;
  bit              curLz = 1'b0;

  task automatic chkv(input string nm, input int got, input int want);
    nChecks++;
    if (got != want) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic modelEdge(input bit r, input bit ld, input bit [4*ND-1:0] val,
                           input bit lz);
    exp_t        e;
    int unsigned d;
    int unsigned w;
    bit          wrap;
    wrap = !r && (pos == PER - 1);
    if (r) begin
      pos      = 0;
      frameVal = '0;
      pendV    = 1'b0;
      lastDec  = 4'h0;
      curSup   = 1'b0;
    end else begin
      pos = (pos + 1) % PER;
      if (pos == BL) begin
        if (ld) frameVal = val;
        else if (pendV) frameVal = pendVal;
        pendV = 1'b0;
      end else if (ld) begin
        pendVal = val;
        pendV   = 1'b1;
      end
    end
    d = pos / SLOT;
    w = pos % SLOT;
    if (!r && w == BL) begin
      lastDec = 4'(frameVal >> (4 * d));
      curSup  = lz && (d > 0) && ((frameVal >> (4 * d)) == 0);
    end
    e.dec = lastDec;
    e.fd  = wrap;
    if (!r && w >= BL && !curSup) begin
      e.an = ~(ND'(1) << d);
      e.sb = 1'b0;
    end else begin
      e.an = '1;
      e.sb = 1'b1;
    end
    expQ.push_back(e);
  endtask

  // Drive one cycle's inputs at the falling edge and queue the expectation.
  task automatic step(input bit r, input bit ld, input bit [4*ND-1:0] val,
                      input bit lz);
    @(negedge clk);
    reset    = r;
    load     = ld;
    value    = val;
    lz_blank = lz;
    modelEdge(r, ld, val, lz);
  endtask

  // Idle until the next step will be presented during frame position p.
  task automatic goToPos(input int unsigned p);
    for (int k = 0; k < int'(PER) && pos != p; k++) step(1'b0, 1'b0, '0, curLz);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, curLz);
  endtask

  // Scoreboard monitor: one expectation per clock, sampled after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        mexp = expQ.pop_front();
        nChecks++;
        if (mexp !== {dec_in, an_n, seg_blank, frame_done}) begin
          nFails++;
          $display("FAIL scoreboard t=%0t: got dec=%h an=%b sb=%b fd=%b, expected dec=%h an=%b sb=%b fd=%b",
                   $time, dec_in, an_n, seg_blank, frame_done,
                   mexp.dec, mexp.an, mexp.sb, mexp.fd);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    value    = '0;
    lz_blank = 1'b0;

    // Reset, then 1234 loaded in cycle 0; check the first frame's timing.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 30; c++) begin
      step(1'b0, c == 0, 16'h1234, 1'b0);
      if (c == 0) begin
        chkv("reset_an", int'(an_n), 'hF);
        chkv("reset_sb", int'(seg_blank), 1);
        chkv("reset_dec", int'(dec_in), 0);
      end
      if (c == 1) chkv("blank1_an", int'(an_n), 'hF);
      if (c == 2) begin
        chkv("d0_an", int'(an_n), 'b1110);
        chkv("d0_dec", int'(dec_in), 4);
      end
      if (c == 5) chkv("d0_end_an", int'(an_n), 'b1110);
      if (c == 6) chkv("gap_an", int'(an_n), 'hF);
      if (c == 8) begin
        chkv("d1_an", int'(an_n), 'b1101);
        chkv("d1_dec", int'(dec_in), 3);
      end
      if (c == 23) chkv("fd_early", int'(frame_done), 0);
      if (c == 24) chkv("fd_pulse", int'(frame_done), 1);
      if (c == 25) chkv("fd_one_cycle", int'(frame_done), 0);
    end

    // Mid-frame load must not tear the frame on display.
    goToPos(9);
    step(1'b0, 1'b1, 16'hABCD, curLz);
    idle(2 * PER);

    // Leading-zero suppression, then an all-zero value.
    curLz = 1'b1;
    goToPos(10);
    step(1'b0, 1'b1, 16'h0050, curLz);
    idle(2 * PER);
    step(1'b0, 1'b1, 16'h0000, curLz);
    idle(2 * PER);
    curLz = 1'b0;

    // Load on the exact frame-start transfer edge.
    goToPos(BL - 1);
    step(1'b0, 1'b1, 16'h9999, curLz);
    idle(2 * PER);

    // Two loads in one frame: the last one wins.
    goToPos(5);
    step(1'b0, 1'b1, 16'h1111, curLz);
    goToPos(15);
    step(1'b0, 1'b1, 16'h2222, curLz);
    idle(2 * PER);

    // Reset during digit 2's SHOW window, with a pending load discarded.
    goToPos(2 * SLOT + BL + 1);
    step(1'b0, 1'b1, 16'h7777, curLz);
    step(1'b1, 1'b0, '0, curLz);
    step(1'b0, 1'b0, '0, curLz);
    chkv("midrst_an", int'(an_n), 'hF);
    chkv("midrst_fd", int'(frame_done), 0);
    chkv("midrst_dec", int'(dec_in), 0);
    step(1'b0, 1'b0, '0, curLz);
    step(1'b0, 1'b0, '0, curLz);
    chkv("midrst_d0_an", int'(an_n), 'b1110);
    chkv("midrst_d0_dec", int'(dec_in), 0);
    idle(PER);

    // Randomized traffic: loads, small values, lz toggling, rare resets.
    for (int k = 0; k < 800; k++) begin
      bit            r;
      bit            ld;
      bit [4*ND-1:0] v;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : (16'($urandom) & 16'h00F0);
      curLz = ($urandom_range(0, 3) != 0);
      step(r, ld, v, curLz);
    end

    // Drain the scoreboard within a fixed number of cycles.
    step(1'b0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chkv("queue_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
